face_roi_extractor: RTL

//  Buffers one IMG_WIDTH x IMG_HEIGHT greyscale frame as it streams into face_detector,

---
 rtl/face_pkg.sv | 33 +++
 rtl/frame_buffer_ram.sv | 32 +++
 rtl/face_roi_extractor.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/face_pkg.sv
// Shared types and constants for the face ROI extractor.
// Imported by the frame buffer RAM and the extractor top level.
package face_pkg;

    localparam int DEF_IMG_WIDTH  = 64;
    localparam int DEF_IMG_HEIGHT = 64;
    localparam int DEF_OUT_W      = 32;
    localparam int DEF_OUT_H      = 32;
    localparam int ADDR_W         = $clog2(DEF_IMG_WIDTH * DEF_IMG_HEIGHT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FULL,
        EXTRACT,
        DRAIN
    } state_e;

    // Row/window markers that travel with each resampled pixel.
    typedef struct packed {
        logic eol;
        logic eof;
    } beat_tag_t;

    function automatic int log2_of(input int v);
        return $clog2(v);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// Simple dual-port frame store: one write port, one read port with a
// registered (1-cycle latency) output.
module frame_buffer_ram
    import face_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_WIDTH * DEF_IMG_HEIGHT,
    parameter int AW    = ADDR_W,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; its contents
    // are only read after a complete frame has been written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/face_roi_extractor.sv
// Buffers one greyscale frame, then crops a face box and nearest-neighbour
// resamples it to an OUT_W x OUT_H window streamed out over valid/ready.
module face_roi_extractor
    import face_pkg::*;
#(
    parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
    parameter int PIXEL_WIDTH = 8,
    parameter int OUT_W       = DEF_OUT_W,
    parameter int OUT_H       = DEF_OUT_H
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    input  logic                   pixel_valid,
    output logic                   frame_ready,
    input  logic                   roi_req,
    input  logic [7:0]             roi_x,
    input  logic [7:0]             roi_y,
    input  logic [7:0]             roi_w,
    input  logic [7:0]             roi_h,
    output logic                   busy,
    output logic                   err,
    output logic [PIXEL_WIDTH-1:0] out_pixel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_eol,
    output logic                   out_eof
);

    localparam int  NPIX    = IMG_WIDTH * IMG_HEIGHT;
    localparam int  AW      = $clog2(NPIX);
    localparam int  LOG_OW  = log2_of(OUT_W);
    localparam int  LOG_OH  = log2_of(OUT_H);
    localparam int  LOG_IW  = log2_of(IMG_WIDTH);
    localparam bit  IW_POW2 = is_pow2(IMG_WIDTH);
    localparam int  OXW     = (LOG_OW > 0) ? LOG_OW : 1;
    localparam int  OYW     = (LOG_OH > 0) ? LOG_OH : 1;

    state_e state_q;
    logic   frame_ready_q, busy_q, err_q;

    logic [AW-1:0]          wr_addr_q, wr_addr_d;
    logic [7:0]             rx_q, rx_d, ry_q, ry_d, rw_q, rw_d, rh_q, rh_d;
    logic [OXW-1:0]         ox_q, ox_d;
    logic [OYW-1:0]         oy_q, oy_d;
    logic [15:0]            ax_q, ax_d, ay_q, ay_d;
    logic                   rd_vld_q, rd_vld_d;
    beat_tag_t              rd_tag_q, rd_tag_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [PIXEL_WIDTH-1:0] pix0_q, pix0_d, pix1_q, pix1_d;
    beat_tag_t              tag0_q, tag0_d, tag1_q, tag1_d;

    logic                   wr_en, roi_accept, issue, pop, push;
    logic                   start_rej, req_rej;
    logic [7:0]             cur_x, cur_y, cur_w, cur_h;
    logic [OXW-1:0]         cur_ox;
    logic [OYW-1:0]         cur_oy;
    logic [15:0]            cur_ax, cur_ay;
    logic                   cur_eol, cur_eof;
    logic [16:0]            sx_raw, sy_raw, sx_lim, sy_lim;
    logic [AW-1:0]          sx_a, sy_a, rd_addr;
    logic [PIXEL_WIDTH-1:0] rd_data;
    int                     occ;

    assign frame_ready = frame_ready_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign out_valid   = (cnt_q != 2'd0);
    assign out_pixel   = pix0_q;
    assign out_eol     = tag0_q.eol;
    assign out_eof     = tag0_q.eof;

    assign pop  = out_valid && out_ready;
    assign push = rd_vld_q;

    // Issue path: on the accepting cycle the counters are taken as zero and the
    // ROI comes straight from the ports, so the first read issues with roi_req.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // can leave it unassigned and infer a latch.
        wr_en      = (state_q == LOAD) && pixel_valid && !start;
        roi_accept = (state_q == FULL) && roi_req && (roi_w != 8'd0) &&
                     (roi_h != 8'd0) && !start;
        start_rej  = start && ((state_q == EXTRACT) || (state_q == DRAIN));
        req_rej    = roi_req && !roi_accept;

        cur_x  = roi_accept ? roi_x : rx_q;
        cur_y  = roi_accept ? roi_y : ry_q;
        cur_w  = roi_accept ? roi_w : rw_q;
        cur_h  = roi_accept ? roi_h : rh_q;
        cur_ox = roi_accept ? '0 : ox_q;
        cur_oy = roi_accept ? '0 : oy_q;
        cur_ax = roi_accept ? '0 : ax_q;
        cur_ay = roi_accept ? '0 : ay_q;

        cur_eol = (cur_ox == OXW'(OUT_W - 1));
        cur_eof = cur_eol && (cur_oy == OYW'(OUT_H - 1));

        sx_raw = 17'(cur_x) + 17'(cur_ax >> LOG_OW);
        sy_raw = 17'(cur_y) + 17'(cur_ay >> LOG_OH);
        sx_lim = (sx_raw > 17'(IMG_WIDTH - 1))  ? 17'(IMG_WIDTH - 1)  : sx_raw;
        sy_lim = (sy_raw > 17'(IMG_HEIGHT - 1)) ? 17'(IMG_HEIGHT - 1) : sy_raw;
        sx_a   = AW'(sx_lim);
        sy_a   = AW'(sy_lim);
        if (IW_POW2) begin
            rd_addr = (sy_a << LOG_IW) | sx_a;
        end else begin
            rd_addr = sy_a * AW'(IMG_WIDTH) + sx_a;
        end

        occ   = int'(cnt_q) - int'(pop) + int'(rd_vld_q);
        issue = roi_accept || ((state_q == EXTRACT) && (occ < 2));

        wr_addr_d = wr_addr_q;
        if (start && (state_q != EXTRACT) && (state_q != DRAIN)) begin
            wr_addr_d = '0;
        end else if (wr_en) begin
            wr_addr_d = (wr_addr_q == AW'(NPIX - 1)) ? '0 : wr_addr_q + AW'(1);
        end

        rx_d = roi_accept ? roi_x : rx_q;
        ry_d = roi_accept ? roi_y : ry_q;
        rw_d = roi_accept ? roi_w : rw_q;
        rh_d = roi_accept ? roi_h : rh_q;

        ox_d     = ox_q;
        oy_d     = oy_q;
        ax_d     = ax_q;
        ay_d     = ay_q;
        rd_vld_d = issue;
        rd_tag_d = rd_tag_q;
        if (issue) begin
            rd_tag_d = '{eol: cur_eol, eof: cur_eof};
            if (cur_eol) begin
                ox_d = '0;
                ax_d = '0;
                oy_d = cur_oy + OYW'(1);
                ay_d = cur_ay + 16'(cur_h);
            end else begin
                ox_d = cur_ox + OXW'(1);
                ax_d = cur_ax + 16'(cur_w);
                oy_d = cur_oy;
                ay_d = cur_ay;
            end
        end
    end

    // Two-entry output FIFO; slot 0 is the head and drives the outputs, so the
    // presented beat stays put while downstream stalls.
    always_comb begin
        cnt_d  = cnt_q;
        pix0_d = pix0_q;
        pix1_d = pix1_q;
        tag0_d = tag0_q;
        tag1_d = tag1_q;
        case ({push, pop})
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    pix0_d = pix1_q;
                    tag0_d = tag1_q;
                    pix1_d = rd_data;
                    tag1_d = rd_tag_q;
                end else begin
                    pix0_d = rd_data;
                    tag0_d = rd_tag_q;
                end
            end
            2'b01: begin
                pix0_d = pix1_q;
                tag0_d = tag1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    pix0_d = rd_data;
                    tag0_d = rd_tag_q;
                end else begin
                    pix1_d = rd_data;
                    tag1_d = rd_tag_q;
                end
                cnt_d = cnt_q + 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            frame_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            err_q <= start_rej || req_rej;
            case (state_q)
                IDLE: begin
                    if (start) state_q <= LOAD;
                end
                LOAD: begin
                    if (wr_en && (wr_addr_q == AW'(NPIX - 1))) begin
                        state_q       <= FULL;
                        frame_ready_q <= 1'b1;
                    end
                end
                FULL: begin
                    if (start) begin
                        state_q       <= LOAD;
                        frame_ready_q <= 1'b0;
                    end else if (roi_accept) begin
                        state_q <= EXTRACT;
                        busy_q  <= 1'b1;
                    end
                end
                EXTRACT: begin
                    if (issue && cur_eof) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (pop && tag0_q.eof) begin
                        state_q <= FULL;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q <= '0;
            rx_q      <= '0;
            ry_q      <= '0;
            rw_q      <= '0;
            rh_q      <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            ax_q      <= '0;
            ay_q      <= '0;
            rd_vld_q  <= 1'b0;
            rd_tag_q  <= '0;
            cnt_q     <= '0;
            pix0_q    <= '0;
            pix1_q    <= '0;
            tag0_q    <= '0;
            tag1_q    <= '0;
        end else begin
            wr_addr_q <= wr_addr_d;
            rx_q      <= rx_d;
            ry_q      <= ry_d;
            rw_q      <= rw_d;
            rh_q      <= rh_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            ax_q      <= ax_d;
            ay_q      <= ay_d;
            rd_vld_q  <= rd_vld_d;
            rd_tag_q  <= rd_tag_d;
            cnt_q     <= cnt_d;
            pix0_q    <= pix0_d;
            pix1_q    <= pix1_d;
            tag0_q    <= tag0_d;
            tag1_q    <= tag1_d;
        end
    end

    frame_buffer_ram #(
        .DEPTH (NPIX),
        .AW    (AW),
        .DW    (PIXEL_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr_q),
        .wr_data (pixel_in),
        .rd_en   (issue),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
